// File: rtl/icdf_seg_fetch_if.sv
// Bundles the sample input, coefficient-table write port and multiply-add
// stage outputs of icdf_seg_fetch into one interface.
interface icdf_seg_fetch_if;
  logic [31:0] u_in;
  logic        u_valid;
  logic        u_ready;
  logic        cfg_we;
  logic [5:0]  cfg_addr;
  logic [35:0] cfg_data;
  logic [17:0] coef1;
  logic [17:0] coef2;
  logic [14:0] masked_out;
  logic        sign_out;
  logic        en_ma18;
  logic        out_ready;

  modport master (
    output u_in, u_valid, cfg_we, cfg_addr, cfg_data, out_ready,
    input  u_ready, coef1, coef2, masked_out, sign_out, en_ma18
  );

  modport slave (
    input  u_in, u_valid, cfg_we, cfg_addr, cfg_data, out_ready,
    output u_ready, coef1, coef2, masked_out, sign_out, en_ma18
  );
endinterface

// File: rtl/icdf_seg_fetch.sv
// Inverse-CDF segment fetch: turns a uniform word into a segment address and
// fraction, then reads that segment's coefficients from a 64-entry table.
module icdf_seg_fetch (
  input logic             clk,
  input logic             rst,
  icdf_seg_fetch_if.slave bus
);
  localparam int unsigned XW    = 31;
  localparam int unsigned LW    = 4;
  localparam int unsigned AW    = 6;
  localparam int unsigned CW    = 18;
  localparam int unsigned MW    = 15;
  localparam int unsigned DEPTH = 64;

  logic              w_stall;
  logic              w_adv;

  logic              r_v1;
  logic [XW-1:0]     r_x1;
  logic              r_s1;

  logic              r_v2;
  logic [AW-1:0]     r_addr2;
  logic [MW-1:0]     r_mask2;
  logic              r_s2;

  logic              r_v3;
  logic [CW-1:0]     r_coef1;
  logic [CW-1:0]     r_coef2;
  logic [MW-1:0]     r_mask3;
  logic              r_s3;

  logic [2*CW-1:0]   r_tbl [DEPTH];

  logic [LW-1:0]     w_lz;
  logic [4:0]        w_sh;
  logic [16:0]       w_top;

  // Whole pipe advances together; bubbles move forward whenever the output is not blocked.
  assign w_stall     = r_v3 & ~bus.out_ready;
  assign w_adv       = ~w_stall;
  assign bus.u_ready = w_adv;

  // Leading-zero count over x[30:16], saturating at 15 when that field is empty.
  always_comb begin
    w_lz = 4'd15;
    for (int i = 16; i <= 30; i++) begin
      if (r_x1[i]) w_lz = LW'(30 - i);
    end
    w_sh  = (w_lz == 4'd15) ? 5'd15 : 5'(w_lz) + 5'd1;
    w_top = 17'((r_x1 << w_sh) >> 14);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_v1 <= 1'b0;
      r_x1 <= '0;
      r_s1 <= 1'b0;
    end else if (w_adv) begin
      r_v1 <= bus.u_valid;
      r_x1 <= bus.u_in[30:0];
      r_s1 <= bus.u_in[31];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_v2    <= 1'b0;
      r_addr2 <= '0;
      r_mask2 <= '0;
      r_s2    <= 1'b0;
    end else if (w_adv) begin
      r_v2    <= r_v1;
      r_addr2 <= {w_lz, w_top[16:15]};
      r_mask2 <= w_top[14:0];
      r_s2    <= r_s1;
    end
  end

  // Table writes ignore stall; a same-edge read in S3 still sees the old entry.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) r_tbl[i] <= '0;
    end else if (bus.cfg_we) begin
      r_tbl[bus.cfg_addr] <= bus.cfg_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_v3    <= 1'b0;
      r_coef1 <= '0;
      r_coef2 <= '0;
      r_mask3 <= '0;
      r_s3    <= 1'b0;
    end else if (w_adv) begin
      r_v3    <= r_v2;
      r_coef1 <= r_tbl[r_addr2][CW-1:0];
      r_coef2 <= r_tbl[r_addr2][2*CW-1:CW];
      r_mask3 <= r_mask2;
      r_s3    <= r_s2;
    end
  end

  assign bus.en_ma18    = r_v3;
  assign bus.coef1      = r_coef1;
  assign bus.coef2      = r_coef2;
  assign bus.masked_out = r_mask3;
  assign bus.sign_out   = r_s3;
endmodule

// File: doc/icdf_seg_fetch.md
ICDF_SEG_FETCH -- requirements
Module: icdf_seg_fetch

Interface
REQ-001 SHALL have port clk, input, 1, single clock; all registers on rising edge.
REQ-002 SHALL have port rst, input, 1, reset, asynchronous and active-low: asserted at 0 and released at 1.
REQ-003 SHALL have port u_in, input, 32, uniform random word; bit 31 is sign, bits 30:0 are the magnitude x.
REQ-004 SHALL have port u_valid, input, 1, u_in valid.
REQ-005 SHALL have port u_ready, output, 1, block accepts u_in this cycle.
REQ-006 SHALL have port cfg_we, input, 1, coefficient table write enable.
REQ-007 SHALL have port cfg_addr, input, 6, table entry index.
REQ-008 SHALL have port cfg_data, input, 36, entry data: {coef2[17:0], coef1[17:0]}.
REQ-009 SHALL have port coef1, output, 18, segment offset coefficient to the multiply-add stage.
REQ-010 SHALL have port coef2, output, 18, segment slope coefficient to the multiply-add stage.
REQ-011 SHALL have port masked_out, output, 15, masked fraction to the multiply-add stage.
REQ-012 SHALL have port sign_out, output, 1, u_in[31] aligned with the data.
REQ-013 SHALL have port en_ma18, output, 1, output valid; drives the multiply-add enable.
REQ-014 SHALL have port out_ready, input, 1, downstream accepts the output.

Function
REQ-015 SHALL be a 3-stage pipeline: S1 captures u_in/sign, S2 computes address/mask, S3 performs the registered table read; en_ma18 rises 3 cycles after acceptance with no stall.
REQ-016 SHALL accept a word when u_valid & u_ready.
REQ-017 SHALL stall when en_ma18 & ~out_ready; during a stall all stages hold and u_ready=0.
REQ-018 SHALL drive u_ready = ~stall (combinational).
REQ-019 SHALL compute lz = leading zeros of x[30:0], saturated to lz_sat=15 when x[30:16]==0.
REQ-020 SHALL shift x (31 bits, truncating) as follows: lz<15 -> shifted = x<<(lz+1), dropping the leading one; lz_sat=15 -> shifted = x<<15.
REQ-021 SHALL form sub = shifted[30:29], masked_out = shifted[28:14], and table address = {lz_sat[3:0], sub}.
REQ-022 SHALL output coef1 = table[addr][17:0] and coef2 = table[addr][35:18], read through a register in S3.
REQ-023 SHALL implement the table as 64x36 registers; a write takes effect on the clock edge when cfg_we=1, regardless of stall.
REQ-024 SHALL return the old entry contents to S3 when a write and a read hit the same address in the same cycle; the new value is seen from the next read.
REQ-025 SHALL move valid bits with the data; bubbles propagate, so an empty stage does not block an upstream stage when not stalled.
REQ-026 SHALL hold en_ma18, coef1, coef2, masked_out and sign_out stable while stalled.

Reset
REQ-027 SHALL, while rst=0, clear all stage valids, coef1, coef2, masked_out, sign_out and en_ma18 to 0; u_ready=1 after reset.
REQ-028 SHALL reset table contents to 0.
REQ-029 SHALL, on reset mid-operation, discard in-flight words; no output appears after release until a new word is accepted.

Verification
REQ-030 Write table[6]={18'h00002,18'h00001}; u_in=32'h3000_0000 with out_ready=1 -> 3 cycles later en_ma18=1, coef1=18'h00001, coef2=18'h00002, masked_out=0, sign_out=0.
REQ-031 u_in=32'h8000_FFFF -> address 63, masked_out=15'h7FFE, sign_out=1; u_in=0 -> address 60, masked_out=0.
REQ-032 u_in=32'h4000_0000 -> address 0, masked_out=0; stream 8 back-to-back words with out_ready=1 -> 8 consecutive en_ma18 cycles, in order.
REQ-033 Hold out_ready=0 for 5 cycles with the pipe full -> u_ready=0, outputs frozen, no loss or duplication after release.
REQ-034 cfg_we to address 6 in the same cycle S3 reads address 6 -> old data output; the next word to address 6 gets the new data.
REQ-035 Pull rst=0 asynchronously between clock edges with 3 words in flight -> en_ma18=0 immediately; after release with u_valid=0, en_ma18 stays 0.
